// File: rtl/counter_sequencer.sv
// Run/stop/load sequencer for the display counter: turns button levels into
// edge events, divides the clock into count ticks and steps between limits.
module counter_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             CLOCK_50_I,
  input  logic             reset,
  input  logic [3:0]       button_status,
  input  logic [WIDTH-1:0] limit_low,
  input  logic [WIDTH-1:0] limit_high,
  input  logic [WIDTH-1:0] load_value,
  input  logic             bounce_mode,
  output logic [WIDTH-1:0] count_value,
  output logic [1:0]       state_o,
  output logic             direction,
  output logic             tick_o,
  output logic             limit_hit
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_UP      = 2'b01,
    ST_DOWN    = 2'b10,
    ST_LOAD    = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              dir_q, dir_d;
  logic              tick_q, tick_d;
  logic              hit_q, hit_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [3:0]        hist_q;
  logic              armed_q;

  logic [3:0]        evt;
  logic              any_evt;
  logic              run;
  logic              tick;
  logic [WIDTH-1:0]  lo_eff;
  logic [WIDTH-1:0]  hi_eff;
  logic [WIDTH-1:0]  load_clamped;

  // Events are suppressed for one cycle after reset so a button held through
  // reset is captured into history rather than seen as a fresh press.
  always_comb begin
    evt          = armed_q ? (button_status & ~hist_q) : 4'b0000;
    any_evt      = |evt;
    run          = (state_q == ST_UP) || (state_q == ST_DOWN);
    tick         = run && (presc_q == PRESC_MAX);
    lo_eff       = (limit_low > limit_high) ? '0 : limit_low;
    hi_eff       = (limit_low > limit_high) ? '1 : limit_high;
    load_clamped = (load_value < lo_eff) ? lo_eff :
                   (load_value > hi_eff) ? hi_eff : load_value;
  end

  // Next-state, count and pulse outputs; a tick alongside any event is dropped.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    tick_d  = tick;
    case (state_q)
      ST_STOPPED: begin
        if (evt[3])                state_d = ST_LOAD;
        else if (evt[0])           state_d = dir_q ? ST_DOWN : ST_UP;
        else if (evt[1] ^ evt[2])  dir_d   = evt[2];
      end
      ST_UP: begin
        if (evt[3])                state_d = ST_LOAD;
        else if (evt[0])           state_d = ST_STOPPED;
        else if (evt[2] && !evt[1]) begin
          state_d = ST_DOWN;
          dir_d   = 1'b1;
        end else if (tick && !any_evt) begin
          if (count_q >= hi_eff) begin
            hit_d = 1'b1;
            if (bounce_mode) begin
              count_d = hi_eff;
              state_d = ST_DOWN;
              dir_d   = 1'b1;
            end else begin
              count_d = lo_eff;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      ST_DOWN: begin
        if (evt[3])                state_d = ST_LOAD;
        else if (evt[0])           state_d = ST_STOPPED;
        else if (evt[1] && !evt[2]) begin
          state_d = ST_UP;
          dir_d   = 1'b0;
        end else if (tick && !any_evt) begin
          if (count_q <= lo_eff) begin
            hit_d = 1'b1;
            if (bounce_mode) begin
              count_d = lo_eff;
              state_d = ST_UP;
              dir_d   = 1'b0;
            end else begin
              count_d = hi_eff;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      ST_LOAD: begin
        count_d = load_clamped;
        state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Prescaler keeps running across an up/down switch, clears otherwise.
  always_comb begin
    presc_d = '0;
    if (run && ((state_d == ST_UP) || (state_d == ST_DOWN)) && !tick)
      presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      count_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      presc_q <= '0;
      hist_q  <= 4'b0000;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      hit_q   <= hit_d;
      presc_q <= presc_d;
      hist_q  <= button_status;
      armed_q <= 1'b1;
    end
  end

  assign count_value = count_q;
  assign state_o     = state_q;
  assign direction   = dir_q;
  assign tick_o      = tick_q;
  assign limit_hit   = hit_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: tick-by-tick expectations are queued
// by the stimulus and checked by a monitor on every tick_o pulse.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button_status = 4'b0000;
  logic [7:0] limit_low = 8'd0;
  logic [7:0] limit_high = 8'd9;
  logic [7:0] load_value = 8'd0;
  logic       bounce_mode = 1'b0;
  logic [7:0] count_value;
  logic [1:0] state_o;
  logic       direction;
  logic       tick_o;
  logic       limit_hit;

  counter_sequencer #(.WIDTH(8), .TICK_DIV(4)) dut (
    .CLOCK_50_I   (clk),
    .reset        (reset),
    .button_status(button_status),
    .limit_low    (limit_low),
    .limit_high   (limit_high),
    .load_value   (load_value),
    .bounce_mode  (bounce_mode),
    .count_value  (count_value),
    .state_o      (state_o),
    .direction    (direction),
    .tick_o       (tick_o),
    .limit_hit    (limit_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic       hit;
    logic [1:0] st;
    logic       dir;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_tick = 0;

  always @(posedge clk) cyc++;

  // Monitor: every tick pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && tick_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_tick: got cnt=%0d hit=%0d st=%0d, want no tick",
                 count_value, limit_hit, state_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (count_value !== e.cnt || limit_hit !== e.hit ||
            state_o !== e.st || direction !== e.dir) begin
          n_bad++;
          $display("FAIL tick_step: got cnt=%0d hit=%0d st=%0d dir=%0d, want cnt=%0d hit=%0d st=%0d dir=%0d",
                   count_value, limit_hit, state_o, direction, e.cnt, e.hit, e.st, e.dir);
        end
        if (e.gap != 0) begin
          n_cmp++;
          if (cyc - last_tick != e.gap) begin
            n_bad++;
            $display("FAIL tick_spacing: got %0d cycles want %0d", cyc - last_tick, e.gap);
          end
        end
      end
      last_tick = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int cnt, input int hit, input int st, input int dir, input int gap);
    exp_t e;
    e.cnt = 8'(cnt);
    e.hit = 1'(hit);
    e.st  = 2'(st);
    e.dir = 1'(dir);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Raise the given buttons for one edge; returns just after the event edge.
  task automatic press(input logic [3:0] m);
    @(posedge clk); #1 button_status = m;
    @(posedge clk); #1 button_status = 4'b0000;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_count", count_value, 0);
    chk("rst_state", state_o, 0);
    chk("rst_dir", direction, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_hit", limit_hit, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Wrap run 0..9 then back to 0
    press(4'b0001);
    @(negedge clk); chk("start_up_state", state_o, 1);
    for (int i = 1; i <= 9; i++) push(i, 0, 1, 0, (i == 1) ? 0 : 4);
    push(0, 1, 1, 0, 4);
    push(1, 0, 1, 0, 4);
    wait_drain();
    press(4'b0001);
    @(negedge clk);
    chk("stop_state", state_o, 0);
    chk("stop_count", count_value, 1);

    // Bounce between 3 and 5
    limit_low = 8'd3; limit_high = 8'd5; bounce_mode = 1'b1; load_value = 8'd4;
    press(4'b1000);
    @(negedge clk); chk("load_state", state_o, 3);
    @(negedge clk); chk("load_done_state", state_o, 0);
    chk("load_count4", count_value, 4);
    press(4'b0001);
    push(5, 0, 1, 0, 0);
    push(5, 1, 2, 1, 0);
    push(4, 0, 2, 1, 0);
    push(3, 0, 2, 1, 0);
    push(3, 1, 1, 0, 0);
    push(4, 0, 1, 0, 0);
    wait_drain();
    press(4'b0001);
    @(negedge clk); chk("bounce_stop_state", state_o, 0);

    // Load while counting, clamped to limits
    limit_low = 8'd10; limit_high = 8'd20; bounce_mode = 1'b0; load_value = 8'd30;
    press(4'b0001);
    push(5, 0, 1, 0, 0);
    wait_drain();
    press(4'b1000);
    @(negedge clk); chk("run_load_state", state_o, 3);
    @(negedge clk); chk("run_load_after", state_o, 0);
    chk("clamp_hi", count_value, 20);
    load_value = 8'd2;
    press(4'b1000);
    @(negedge clk); @(negedge clk);
    chk("clamp_lo", count_value, 10);

    // Direction events, simultaneous up/down ignored
    press(4'b0110);
    @(negedge clk); chk("both_dir_ignored", direction, 0);
    press(4'b0100);
    @(negedge clk); chk("dir_down", direction, 1);
    chk("dir_down_state", state_o, 0);
    press(4'b0110);
    @(negedge clk); chk("both_dir_ignored2", direction, 1);
    press(4'b0001);
    @(negedge clk); chk("start_down_state", state_o, 2);
    push(20, 1, 2, 1, 0);
    wait_drain();
    load_value = 8'd15;
    press(4'b1001);
    @(negedge clk); chk("load_wins_state", state_o, 3);
    @(negedge clk); chk("load_wins_after", state_o, 0);
    chk("load_wins_count", count_value, 15);
    chk("load_keeps_dir", direction, 1);
    press(4'b0010);
    @(negedge clk); chk("dir_up", direction, 0);

    // Inverted limits: full range, wrap from 255
    limit_low = 8'd8; limit_high = 8'd2; load_value = 8'd255;
    press(4'b1000);
    @(negedge clk); @(negedge clk);
    chk("load_255", count_value, 255);
    press(4'b0001);
    push(0, 1, 1, 0, 0);
    push(1, 0, 1, 0, 4);
    wait_drain();

    // Asynchronous reset mid-count with start button held through it
    push(2, 0, 1, 0, 4);
    wait_drain();
    @(posedge clk); #2;
    reset = 1'b1;
    button_status = 4'b0001;
    #1;
    chk("async_rst_count", count_value, 0);
    chk("async_rst_state", state_o, 0);
    chk("async_rst_dir", direction, 0);
    chk("async_rst_tick", tick_o, 0);
    chk("async_rst_hit", limit_hit, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_btn_no_event", state_o, 0);
    @(posedge clk); #1 button_status = 4'b0000;
    press(4'b0001);
    @(negedge clk); chk("repress_start", state_o, 1);
    press(4'b0001);
    @(negedge clk); chk("final_stop", state_o, 0);
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
